// File: rtl/booth4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate unit.
package booth4_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Recoded Booth digit: multiple of the multiplicand to add.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_e;

    // Number of Booth digits for a WIDTH-bit operand that has been
    // extended by two bits, so unsigned operands are also covered.
    function automatic int unsigned booth_digits(input int unsigned width);
        return (width / 32'd2) + 32'd1;
    endfunction

endpackage

// File: rtl/booth4_mac_seq_if.sv
// Operand/result handshake bundle for booth4_mac_seq.
interface booth4_mac_seq_if #(
    parameter int WIDTH = 256,
    parameter int GUARD = 8
);
    localparam int ACC_W = 2 * WIDTH + GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             op_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, signed_mode, op_acc, acc_clr, out_ready,
        input  in_ready, out_valid, result
    );

    // The multiply-accumulate unit itself.
    modport slave (
        input  in_valid, a, b, signed_mode, op_acc, acc_clr, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth triplet encoder and partial-product selector.
// Negative digits are returned as the bitwise inverse of the positive
// multiple; o_neg supplies the +1 that completes the two's complement.
module booth4_pp_gen
    import booth4_pkg::*;
#(
    parameter int XW = 10
) (
    input  logic [XW-1:0] i_a,
    input  logic [2:0]    i_trip,
    output logic [XW:0]   o_pp,
    output logic          o_neg
);

    digit_e w_digit;

    // Recode the overlapping multiplier triplet into a Booth digit.
    always_comb begin
        w_digit = ZERO;
        case (i_trip)
            3'b001, 3'b010: w_digit = P1;
            3'b011:         w_digit = P2;
            3'b100:         w_digit = M2;
            3'b101, 3'b110: w_digit = M1;
            default:        w_digit = ZERO;
        endcase
    end

    // Select the signed multiple of the multiplicand for this digit.
    always_comb begin
        o_pp  = {(XW+1){1'b0}};
        o_neg = 1'b0;
        case (w_digit)
            P1: o_pp = {i_a[XW-1], i_a};
            P2: o_pp = {i_a, 1'b0};
            M1: begin
                o_pp  = ~{i_a[XW-1], i_a};
                o_neg = 1'b1;
            end
            M2: begin
                o_pp  = ~{i_a, 1'b0};
                o_neg = 1'b1;
            end
            default: begin
                o_pp  = {(XW+1){1'b0}};
                o_neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth4_mac_seq.sv
// Sequential radix-4 Booth multiply-accumulate unit: one Booth digit per
// cycle, then an optional add into a guard-bit-extended accumulator.
module booth4_mac_seq
    import booth4_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int GUARD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    booth4_mac_seq_if.slave bus
);

    localparam int ACC_W = 2 * WIDTH + GUARD;
    localparam int N     = int'(booth_digits(WIDTH));
    localparam int XW    = WIDTH + 2;       // extended operand width
    localparam int PW    = 2 * WIDTH;       // exact product width
    localparam int CW    = $clog2(N + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [XW-1:0]    r_a;
    logic [XW:0]      r_b_sh;               // extended multiplier with b[-1]=0 appended
    logic [PW-1:0]    r_psum;
    logic             r_signed;
    logic             r_op_acc;
    logic             r_clr;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_hs_in;
    logic             w_last;
    logic [XW-1:0]    w_a_ext;
    logic [XW-1:0]    w_b_ext;
    logic [XW:0]      w_pp;
    logic             w_neg;
    logic [CW:0]      w_shamt;
    logic [PW-1:0]    w_pp_sh;
    logic [PW-1:0]    w_neg_sh;
    logic [PW-1:0]    w_psum_nxt;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_hs_in = bus.in_valid && r_in_ready;
    assign w_last  = (r_cnt == CW'(N - 1));

    // Extra two bits let unsigned operands pass through signed Booth recoding.
    assign w_a_ext = {{2{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
    assign w_b_ext = {{2{bus.signed_mode & bus.b[WIDTH-1]}}, bus.b};

    booth4_pp_gen #(.XW(XW)) u_pp_gen (
        .i_a    (r_a),
        .i_trip (r_b_sh[2:0]),
        .o_pp   (w_pp),
        .o_neg  (w_neg)
    );

    // Digit k carries weight 4^k; arithmetic wraps modulo 2^PW which is exact.
    assign w_shamt    = {r_cnt, 1'b0};
    assign w_pp_sh    = {{(PW-XW-1){w_pp[XW]}}, w_pp} << w_shamt;
    assign w_neg_sh   = {{(PW-1){1'b0}}, w_neg} << w_shamt;
    assign w_psum_nxt = r_psum + w_pp_sh + w_neg_sh;

    // Product widened to the accumulator according to the operand mode.
    assign w_prod_ext = {{GUARD{r_signed & r_psum[PW-1]}}, r_psum};
    assign w_acc_base = r_clr ? {ACC_W{1'b0}} : r_acc;
    assign w_acc_nxt  = (r_op_acc ? w_acc_base : {ACC_W{1'b0}}) + w_prod_ext;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    // Next-state logic for the transaction controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs_in) w_state_nxt = CALC;
                else         w_state_nxt = IDLE;
            end
            CALC: begin
                if (w_last) w_state_nxt = ACCUM;
                else        w_state_nxt = CALC;
            end
            ACCUM: w_state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
                else               w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, handshake flags, datapath and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_a         <= {XW{1'b0}};
            r_b_sh      <= {(XW+1){1'b0}};
            r_psum      <= {PW{1'b0}};
            r_signed    <= 1'b0;
            r_op_acc    <= 1'b0;
            r_clr       <= 1'b0;
            r_acc       <= {ACC_W{1'b0}};
            r_result    <= {ACC_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (w_hs_in) begin
                        r_a      <= w_a_ext;
                        r_b_sh   <= {w_b_ext, 1'b0};
                        r_signed <= bus.signed_mode;
                        r_op_acc <= bus.op_acc;
                        r_clr    <= bus.acc_clr;
                        r_cnt    <= {CW{1'b0}};
                        r_psum   <= {PW{1'b0}};
                    end
                end
                CALC: begin
                    r_psum <= w_psum_nxt;
                    r_b_sh <= {2'b00, r_b_sh[XW:2]};
                    if (!w_last) r_cnt <= r_cnt + CW'(1);
                end
                ACCUM: begin
                    r_acc    <= w_acc_nxt;
                    r_result <= w_acc_nxt;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_mac_seq.sv
// Directed scoreboard bench for booth4_mac_seq (WIDTH=8, GUARD=8, N=5).
module tb_booth4_mac_seq;

    localparam int WIDTH = 8;
    localparam int GUARD = 8;
    localparam int ACC_W = 24;
    localparam int N     = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth4_mac_seq_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

    booth4_mac_seq #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every result accepted downstream is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", bus.result);
            end else begin
                check("result", {8'h00, bus.result}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic oa, input logic clr, input logic push,
                        input logic [ACC_W-1:0] exp);
        int t = 0;
        bus.a = a; bus.b = b; bus.signed_mode = sm; bus.op_acc = oa; bus.acc_clr = clr;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) begin
            check("send_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int first;
        int t;
        int prod;
        logic [ACC_W-1:0] e;

        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        bus.signed_mode = 1'b0; bus.op_acc = 1'b0; bus.acc_clr = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result",    {8'h00, bus.result},    32'd0);
        rst_n = 1'b1;

        // Unsigned 255*255 and first-valid latency
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00FE01);
        first = 0;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1 && first == 0) first = k + 1;
        end
        check("latency_cycle", first, 32'd7);

        // Signed corner products
        send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 24'h004000);
        send(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFC080);

        // MAC sequence
        send(8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 1'b1, 24'h002710);
        send(8'hFF,  8'h01,  1'b1, 1'b1, 1'b0, 1'b1, 24'h00270F);
        send(8'h03,  8'h04,  1'b0, 1'b1, 1'b1, 1'b1, 24'h00000C);

        // Backpressure: result held, no new transaction accepted
        wait_idle();
        bus.out_ready = 1'b0;
        send(8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00001E);
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("bp_reach_done", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.a = 8'($urandom_range(0, 255));
            bus.b = 8'($urandom_range(0, 255));
            bus.acc_clr = ~i[1];
            bus.op_acc = i[2];
            @(posedge clk); #1;
            check("bp_result",    {8'h00, bus.result},    32'h0000001E);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid = 1'b0; bus.acc_clr = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        send(8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000024);

        // Reset in the middle of CALC aborts the operation
        wait_idle();
        send(8'h07, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_result", {8'h00, bus.result}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        send(8'h03, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 24'h00000C);

        // Accumulator wrap: 259 accumulated 255*255 products after a clear
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00FE01);
        for (int k = 2; k <= 259; k++) begin
            prod = k * 65025;
            e = prod[23:0];
            if (k == 259) e = 24'h00FB03;
            send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, e);
        end

        // Drain the scoreboard
        wait_idle();
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
